// File: rtl/multi_vc_in_port_pkg.sv
// rtl/multi_vc_in_port_pkg.sv - shared defaults, flit bit positions and credit types for multi_vc_in_port
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif
`ifndef FLIT_BUFFER_DEPTH
`define FLIT_BUFFER_DEPTH 4
`endif

package connect_inport_pkg;
    localparam int DEF_FLIT_W  = `FLIT_WIDTH;
    localparam int DEF_DEPTH   = `FLIT_BUFFER_DEPTH;
    localparam int DEF_NUM_VCS = 2;
    localparam int DEF_VC_W    = $clog2(DEF_NUM_VCS);

    // Flit layout: MSB is the valid bit, the bit below it marks a tail flit.
    localparam int VALID_BIT = DEF_FLIT_W - 1;
    localparam int TAIL_BIT  = DEF_FLIT_W - 2;

    // One extra bit so a counter can hold the full DEPTH value.
    typedef logic [$clog2(DEF_DEPTH):0] credit_t;

    typedef struct packed {
        logic                valid;
        logic [DEF_VC_W-1:0] vc;
    } credit_ret_t;
endpackage

// File: rtl/multi_vc_in_port_if.sv
// rtl/multi_vc_in_port_if.sv - device put side and router send/credit side of multi_vc_in_port
// master: device/router environment; slave: the in-port itself.
interface multi_vc_in_port_if
    import connect_inport_pkg::*;
#(
    parameter int FLIT_W = DEF_FLIT_W,
    parameter int VC_W   = DEF_VC_W
);
    logic [FLIT_W-1:0] put_flit;
    logic [VC_W-1:0]   put_vc;
    logic              put_flit_valid;
    logic              put_flit_ready;
    logic [FLIT_W-1:0] send_ports_putFlit_flit_in;
    logic              EN_send_ports_putFlit;
    logic [VC_W:0]     send_ports_getCredits;
    logic              EN_send_ports_getCredits;
    logic              credit_err;

    modport master (
        output put_flit, put_vc, put_flit_valid, send_ports_getCredits,
        input  put_flit_ready, send_ports_putFlit_flit_in, EN_send_ports_putFlit,
               EN_send_ports_getCredits, credit_err
    );

    modport slave (
        input  put_flit, put_vc, put_flit_valid, send_ports_getCredits,
        output put_flit_ready, send_ports_putFlit_flit_in, EN_send_ports_putFlit,
               EN_send_ports_getCredits, credit_err
    );
endinterface

// File: rtl/multi_vc_in_port_fifo.sv
// rtl/multi_vc_in_port_fifo.sv - per-VC flit FIFO (vc_flit_fifo), pointer plus maybe_full scheme
// Ports: CLK, RST_N (async active-low), wr_en/wr_data, rd_en/rd_data (head, show-ahead), full, empty.
// Callers gate wr_en with !full and rd_en with !empty.
module vc_flit_fifo
    import connect_inport_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_FLIT_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             maybe_full;

    // Equal pointers are ambiguous; maybe_full remembers whether the last
    // occupancy change was a write (full) or a read (empty).
    assign full    = (wr_ptr == rd_ptr) && maybe_full;
    assign empty   = (wr_ptr == rd_ptr) && !maybe_full;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            maybe_full <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en != rd_en) begin
                maybe_full <= wr_en;
            end
        end
    end
endmodule

// File: rtl/multi_vc_in_port.sv
// rtl/multi_vc_in_port.sv - multi-VC network injection port: per-VC FIFOs and credits, round-robin send
// Ports: CLK, RST_N (async active-low); port (multi_vc_in_port_if.slave):
//   put_flit/put_vc/put_flit_valid/put_flit_ready - device side, ready = FIFO[put_vc] not full
//   send_ports_putFlit_flit_in/EN_send_ports_putFlit - registered flit and strobe to the router
//   send_ports_getCredits {valid, vc} in, EN_send_ports_getCredits tied high
//   credit_err - sticky, set by a credit return into an already-full counter
// Macro INPORT_WORMHOLE_LOCK_EN: lock the arbiter onto a VC from a non-tail grant until its tail.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif
`ifndef FLIT_BUFFER_DEPTH
`define FLIT_BUFFER_DEPTH 4
`endif

module multi_vc_in_port
    import connect_inport_pkg::*;
#(
    parameter int NUM_VCS = DEF_NUM_VCS,
    parameter int DEPTH   = `FLIT_BUFFER_DEPTH,
    parameter int FLIT_W  = `FLIT_WIDTH
) (
    input logic              CLK,
    input logic              RST_N,
    multi_vc_in_port_if.slave port
);
    localparam int VC_W  = $clog2(NUM_VCS);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int TAIL  = FLIT_W - 2;
    localparam logic [FLIT_W-1:0] VALID_MASK = {1'b1, {(FLIT_W-1){1'b0}}};

    logic [NUM_VCS-1:0] fifo_full;
    logic [NUM_VCS-1:0] fifo_empty;
    logic [NUM_VCS-1:0] eligible;
    logic [NUM_VCS-1:0] cred_ovf;
    logic [FLIT_W-1:0]  head [NUM_VCS];
    logic [CNT_W-1:0]   credit [NUM_VCS];

    logic               cred_valid;
    logic [VC_W-1:0]    cred_vc;
    logic [VC_W-1:0]    last_grant;
    logic [VC_W-1:0]    grant_vc;
    logic [VC_W-1:0]    scan_vc;
    logic               grant_valid;

    logic               en_q;
    logic [FLIT_W-1:0]  flit_q;
    logic               err_q;

    assign cred_valid = port.send_ports_getCredits[VC_W];
    assign cred_vc    = port.send_ports_getCredits[VC_W-1:0];

    // Ready looks only at the addressed FIFO; a same-cycle dequeue does not free a slot.
    assign port.put_flit_ready             = !fifo_full[port.put_vc];
    assign port.send_ports_putFlit_flit_in = flit_q;
    assign port.EN_send_ports_putFlit      = en_q;
    assign port.EN_send_ports_getCredits   = 1'b1;
    assign port.credit_err                 = err_q;

    for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
        logic             wr_en;
        logic             rd_en;
        logic             ret_hit;
        logic [CNT_W-1:0] cnt;

        assign wr_en       = port.put_flit_valid && !fifo_full[v] && (port.put_vc == VC_W'(v));
        assign rd_en       = grant_valid && (grant_vc == VC_W'(v));
        assign ret_hit     = cred_valid && (cred_vc == VC_W'(v));
        assign eligible[v] = !fifo_empty[v] && (cnt != '0);
        assign cred_ovf[v] = ret_hit && !rd_en && (cnt == CNT_W'(DEPTH));
        assign credit[v]   = cnt;

        vc_flit_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (FLIT_W)
        ) u_fifo (
            .CLK     (CLK),
            .RST_N   (RST_N),
            .wr_en   (wr_en),
            .wr_data (port.put_flit),
            .rd_en   (rd_en),
            .rd_data (head[v]),
            .full    (fifo_full[v]),
            .empty   (fifo_empty[v])
        );

        // Grant and return on the same VC cancel; a return into a full counter saturates.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                cnt <= CNT_W'(DEPTH);
            end else if (rd_en && !ret_hit) begin
                cnt <= cnt - 1'b1;
            end else if (ret_hit && !rd_en && (cnt != CNT_W'(DEPTH))) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef INPORT_WORMHOLE_LOCK_EN
    logic            lock_active;
    logic [VC_W-1:0] lock_vc;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lock_active <= 1'b0;
            lock_vc     <= '0;
        end else if (grant_valid) begin
            lock_active <= !head[grant_vc][TAIL];
            lock_vc     <= grant_vc;
        end
    end
`endif

    // Scan from last_grant+1 upward; the i == NUM_VCS step wraps back to last_grant,
    // giving it lowest priority. VC_W-bit arithmetic performs the modulo.
    always_comb begin
        grant_valid = 1'b0;
        grant_vc    = '0;
        scan_vc     = '0;
`ifdef INPORT_WORMHOLE_LOCK_EN
        if (lock_active) begin
            grant_valid = eligible[lock_vc];
            grant_vc    = lock_vc;
        end else begin
`else
        begin
`endif
            for (int i = 1; i <= NUM_VCS; i++) begin
                scan_vc = last_grant + VC_W'(i);
                if (!grant_valid && eligible[scan_vc]) begin
                    grant_valid = 1'b1;
                    grant_vc    = scan_vc;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_grant <= '0;
            en_q       <= 1'b0;
            flit_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            en_q   <= grant_valid;
            flit_q <= grant_valid ? (head[grant_vc] | VALID_MASK) : '0;
            err_q  <= err_q | (|cred_ovf);
            if (grant_valid) begin
                last_grant <= grant_vc;
            end
        end
    end
endmodule
